// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared types and defaults for the debug step controller
package mips_dbg_pkg;

  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP_IDLE = 2'd1,
    ST_STEP_ADV  = 2'd2
  } step_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer followed by a registered rising-edge detector
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   rise_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // armed_q only sets once a genuinely sampled low has reached the output, so an
  // input already high when reset is released cannot fake a rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= sync_out;
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_out);
      rise_q  <= sync_out & ~prev_q & armed_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - run/single-step pipeline advance controller with step counter
module step_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change,
  input  logic             step,
  input  logic             hold,
  output logic             run_en,
  output logic             step_mode,
  output logic             step_done,
  output logic [CNT_W-1:0] step_count
);

  logic        change_rise;
  logic        step_rise;
  step_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_change_edge (
    .clock (clock),
    .reset (reset),
    .d_i   (change),
    .rise_o(change_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_edge (
    .clock (clock),
    .reset (reset),
    .d_i   (step),
    .rise_o(step_rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    step_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (change_rise) state_d = ST_STEP_IDLE;
      end
      ST_STEP_IDLE: begin
        if (change_rise)    state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP_ADV;
      end
      ST_STEP_ADV: begin
        if (hold) begin
          if (change_rise) pend_d = 1'b1;
        end else begin
          // A mode change seen during the stalled advance takes effect once it is consumed.
          step_done = 1'b1;
          pend_d    = 1'b0;
          state_d   = (pend_q || change_rise) ? ST_RUN : ST_STEP_IDLE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (step_done) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign run_en     = (state_q != ST_STEP_IDLE);
  assign step_mode  = (state_q != ST_RUN);
  assign step_count = cnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - scoreboard bench for step_ctrl
module tb_step_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        change = 1'b0;
  logic        step = 1'b0;
  logic        hold = 1'b0;
  logic        run_en, step_mode, step_done;
  logic [15:0] step_count;
  logic        run_en_w, step_mode_w, step_done_w;
  logic [2:0]  step_count_w;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_count = '0;
  logic [15:0] exp_q[$];

  always #10 clock = ~clock;

  step_ctrl dut (
    .clock(clock), .reset(reset), .change(change), .step(step), .hold(hold),
    .run_en(run_en), .step_mode(step_mode), .step_done(step_done), .step_count(step_count)
  );

  // Narrow counter copy so the wrap boundary is reachable in a short run.
  step_ctrl #(.CNT_W(3)) dut_w (
    .clock(clock), .reset(reset), .change(change), .step(step), .hold(hold),
    .run_en(run_en_w), .step_mode(step_mode_w), .step_done(step_done_w), .step_count(step_count_w)
  );

  task automatic toggle_mode();
    @(negedge clock);
    #2 change = 1'b1;
    repeat (3) @(negedge clock);
    change = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({run_en, step_mode, step_done, step_count} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got run_en=%b step_mode=%b step_done=%b count=%h, want 1 0 0 0000",
               run_en, step_mode, step_done, step_count);
    end
    #2 reset = 1'b0;
    exp_count = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      tests_run++;
      if (run_en !== 1'b1 || step_mode !== 1'b0 || step_count !== 16'h0000) begin
        tests_failed++;
        $display("FAIL idle_after_reset[%0d]: got run_en=%b step_mode=%b count=%h, want 1 0 0000",
                 i, run_en, step_mode, step_count);
      end
    end
    #2 reset = 1'b1;
    change = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (10) @(negedge clock);
    tests_run++;
    if (step_mode !== 1'b0) begin
      tests_failed++;
      $display("FAIL high_at_release: got step_mode=%b, want 0", step_mode);
    end
    change = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_change_entry();
    @(negedge clock);
    #2 change = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      tests_run++;
      if (step_mode !== (k >= 4) || run_en !== (k < 4)) begin
        tests_failed++;
        $display("FAIL change_latency[edge %0d]: got step_mode=%b run_en=%b, want %b %b",
                 k, step_mode, run_en, (k >= 4), (k < 4));
      end
      if (k == 3) #2 change = 1'b0;
    end
    repeat (8) @(negedge clock);
    tests_run++;
    if (step_mode !== 1'b1 || run_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL change_fall_ignored: got step_mode=%b run_en=%b, want 1 0", step_mode, run_en);
    end
  endtask

  task automatic do_step(input int hold_cycles);
    int          adv = 0;
    int          done_n = 0;
    logic        chk_pend = 1'b0;
    logic [15:0] popped = '0;
    logic [2:0]  popped_w;
    @(negedge clock);
    hold = (hold_cycles > 0);
    #2 step = 1'b1;
    exp_count = exp_count + 16'd1;
    exp_q.push_back(exp_count);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (chk_pend) begin
        chk_pend = 1'b0;
        popped_w = popped[2:0];
        tests_run++;
        if (step_count !== popped) begin
          tests_failed++;
          $display("FAIL step_count: got %h, want %h", step_count, popped);
        end
        tests_run++;
        if (step_count_w !== popped_w) begin
          tests_failed++;
          $display("FAIL step_count_narrow: got %0d, want %0d", step_count_w, popped_w);
        end
      end
      if (i == 1) step = 1'b0;
      if (run_en) adv++;
      if (adv > hold_cycles) hold = 1'b0;
      #1;
      if (step_done) begin
        done_n++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_step_done: got step_done=1 with empty scoreboard, want 0");
        end else begin
          popped = exp_q.pop_front();
          chk_pend = 1'b1;
        end
      end
    end
    tests_run++;
    if (adv !== hold_cycles + 1) begin
      tests_failed++;
      $display("FAIL run_en_width(hold=%0d): got %0d cycles, want %0d", hold_cycles, adv, hold_cycles + 1);
    end
    tests_run++;
    if (done_n !== 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL step_done_count(hold=%0d): got %0d pulses (%0d pending), want 1 (0 pending)",
               hold_cycles, done_n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_adv(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clock);
      if (i == 1) step = 1'b0;
      if (run_en) seen = 1'b1;
    end
    step = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s_enter_adv: got run_en=0 within budget, want 1", name);
    end
  endtask

  task automatic test_pending();
    logic [15:0] popped = '0;
    @(negedge clock);
    hold = 1'b1;
    #2 step = 1'b1;
    exp_count = exp_count + 16'd1;
    exp_q.push_back(exp_count);
    wait_adv("pending");
    #2 change = 1'b1;
    step = 1'b1;
    repeat (3) @(negedge clock);
    change = 1'b0;
    step = 1'b0;
    repeat (6) @(negedge clock);
    tests_run++;
    if (run_en !== 1'b1 || step_mode !== 1'b1 || step_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL adv_stalled: got run_en=%b step_mode=%b step_done=%b, want 1 1 0",
               run_en, step_mode, step_done);
    end
    hold = 1'b0;
    #1;
    tests_run++;
    if (step_done !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL pending_consume: got step_done=%b, want 1", step_done);
    end else begin
      popped = exp_q.pop_front();
    end
    exp_q.delete();
    @(negedge clock);
    tests_run++;
    if (step_mode !== 1'b0 || run_en !== 1'b1 || step_count !== exp_count) begin
      tests_failed++;
      $display("FAIL pending_to_run: got step_mode=%b run_en=%b count=%h, want 0 1 %h",
               step_mode, run_en, step_count, exp_count);
    end
    repeat (6) @(negedge clock);
    tests_run++;
    if (step_mode !== 1'b0 || step_count !== popped) begin
      tests_failed++;
      $display("FAIL step_not_queued: got step_mode=%b count=%h, want 0 %h", step_mode, step_count, popped);
    end
  endtask

  task automatic test_same_edge();
    logic done_seen = 1'b0;
    toggle_mode();
    tests_run++;
    if (step_mode !== 1'b1 || run_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL toggle_to_idle: got step_mode=%b run_en=%b, want 1 0", step_mode, run_en);
    end
    @(negedge clock);
    #2 change = 1'b1;
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 2) begin
        change = 1'b0;
        step = 1'b0;
      end
      if (step_done) done_seen = 1'b1;
    end
    tests_run++;
    if (step_mode !== 1'b0 || step_count !== exp_count || done_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL change_wins: got step_mode=%b count=%h done_seen=%b, want 0 %h 0",
               step_mode, step_count, done_seen, exp_count);
    end
    @(posedge clock);
    #5 change = 1'b1;
    #1 change = 1'b0;
    repeat (8) @(negedge clock);
    tests_run++;
    if (step_mode !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_ignored: got step_mode=%b, want 0", step_mode);
    end
  endtask

  task automatic test_wrap();
    toggle_mode();
    for (int n = 0; n < 4; n++) begin
      do_step(0);
      if (exp_count == 16'd8) begin
        tests_run++;
        if (step_count_w !== 3'd0) begin
          tests_failed++;
          $display("FAIL narrow_wrap: got %0d, want 0", step_count_w);
        end
      end
    end
  endtask

  task automatic test_reset_mid_adv();
    logic done_seen = 1'b0;
    @(negedge clock);
    hold = 1'b1;
    #2 step = 1'b1;
    wait_adv("reset_mid");
    #3 reset = 1'b1;
    #1;
    exp_count = '0;
    exp_q.delete();
    tests_run++;
    if ({run_en, step_mode, step_done, step_count, step_count_w} !== {1'b1, 1'b0, 1'b0, 16'h0000, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid_adv: got run_en=%b step_mode=%b step_done=%b count=%h/%0d, want 1 0 0 0000/0",
               run_en, step_mode, step_done, step_count, step_count_w);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (step_done) done_seen = 1'b1;
    end
    tests_run++;
    if (step_mode !== 1'b0 || step_count !== 16'h0000 || done_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_mid_adv: got step_mode=%b count=%h done_seen=%b, want 0 0000 0",
               step_mode, step_count, done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_change_entry();
    for (int s = 0; s < 3; s++) do_step(0);
    do_step(4);
    test_pending();
    test_same_edge();
    test_wrap();
    test_reset_mid_adv();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got simulation still running at 200us, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
